// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_ctrl_pkg
//   Shared types and default constants for the SPI arbiter slice.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package spi_ctrl_pkg;

  localparam int SPI_DW      = 12;
  localparam int SPI_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: first set request bit searching upward
//   from last+1 with wrap-around. Returns one-hot select and its index.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         sel,
  output logic [$clog2(NREQ)-1:0] sel_idx
);

  localparam int IW = $clog2(NREQ);

  logic found;
  int   pos;

  // Walk the requesters starting just after the last winner; first hit wins.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = int'(last) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found && req[pos]) begin
        found    = 1'b1;
        sel[pos] = 1'b1;
        sel_idx  = pos[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_arbiter
//   Shares one SPI master transmitter between NREQ requesters. Latches the
//   granted word, holds newd until the master drops cs, waits for cs to rise
//   again (or a timeout) and returns a one-cycle ack with an error flag.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module spi_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = SPI_DW,
  parameter int TIMEOUT = SPI_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  ack,
  output logic             err,
  output logic             busy,
  output logic             spi_newd,
  output logic [DW-1:0]    spi_din,
  input  logic             spi_cs
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  arb_state_t      state, state_nxt;
  logic            cs_meta, cs_s;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [IW-1:0]   last, last_nxt;
  logic [IW-1:0]   gidx, gidx_nxt;
  logic [NREQ-1:0] sel;
  logic [IW-1:0]   sel_idx;
  logic            timeout;

  logic [NREQ-1:0] gnt_nxt, ack_nxt;
  logic            err_nxt, busy_nxt, newd_nxt;
  logic [DW-1:0]   din_nxt;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (req),
    .last    (last),
    .sel     (sel),
    .sel_idx (sel_idx)
  );

  assign timeout = (cnt == CNT_LAST);

  // Two-flop synchronizer for the master's chip select; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta <= 1'b1;
      cs_s    <= 1'b1;
    end else begin
      cs_meta <= spi_cs;
      cs_s    <= cs_meta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; timeout takes priority over cs activity.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req)         state_nxt = LAUNCH;
      LAUNCH:  if (timeout)      state_nxt = DONE;
               else if (!cs_s)   state_nxt = BUSY;
      BUSY:    if (timeout)      state_nxt = DONE;
               else if (cs_s)    state_nxt = DONE;
      DONE:                      state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Output/datapath next values; every output is registered below.
  always_comb begin
    gnt_nxt  = gnt;
    ack_nxt  = '0;
    err_nxt  = 1'b0;
    newd_nxt = spi_newd;
    din_nxt  = spi_din;
    last_nxt = last;
    gidx_nxt = gidx;
    cnt_nxt  = cnt;
    busy_nxt = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (|req) begin
          gnt_nxt  = sel;
          gidx_nxt = sel_idx;
          din_nxt  = wdata[sel_idx*DW +: DW];
          newd_nxt = 1'b1;
        end
      end
      LAUNCH, BUSY: begin
        // Saturate so a stuck transfer can never wrap the counter.
        if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
        if (state_nxt == DONE) begin
          newd_nxt = 1'b0;
          gnt_nxt  = '0;
          ack_nxt  = gnt;
          err_nxt  = timeout;
        end else if (state_nxt == BUSY) begin
          newd_nxt = 1'b0;
        end
      end
      DONE: begin
        last_nxt = gidx;
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= '0;
      ack      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      spi_newd <= 1'b0;
      spi_din  <= '0;
      last     <= IW'(NREQ - 1);
      gidx     <= '0;
      cnt      <= '0;
    end else begin
      gnt      <= gnt_nxt;
      ack      <= ack_nxt;
      err      <= err_nxt;
      busy     <= busy_nxt;
      spi_newd <= newd_nxt;
      spi_din  <= din_nxt;
      last     <= last_nxt;
      gidx     <= gidx_nxt;
      cnt      <= cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_arbiter
//   Table-driven bench for spi_arbiter with a behavioural SPI master model.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_spi_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 12;
  localparam int TIMEOUT = 1024;
  localparam int DIV     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]   gnt, ack;
  logic              err, busy, spi_newd;
  logic [DW-1:0]     spi_din;
  logic              spi_cs = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] words [NREQ];

  always #5 clk = ~clk;

  spi_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wdata    (wdata),
    .gnt      (gnt),
    .ack      (ack),
    .err      (err),
    .busy     (busy),
    .spi_newd (spi_newd),
    .spi_din  (spi_din),
    .spi_cs   (spi_cs)
  );

  // Behavioural SPI master: samples newd on sclk ticks, shifts LSB first.
  logic          stuck = 1'b0;
  int            accept_wait = 0;
  int            div_cnt = 0, wait_cnt = 0, nb = 0, sent_cnt = 0;
  logic          active = 1'b0, mosi = 1'b0;
  logic [DW-1:0] sh = '0, rxw = '0, last_sent = '0;

  always @(posedge clk) begin
    if (rst) begin
      div_cnt  <= 0;
      spi_cs   <= 1'b1;
      active   <= 1'b0;
      nb       <= 0;
      wait_cnt <= 0;
      mosi     <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV-1) ? 0 : div_cnt + 1;
      if (!active) wait_cnt <= spi_newd ? wait_cnt + 1 : 0;
      if (div_cnt == DIV-1) begin
        if (!active) begin
          if (spi_newd && !stuck && wait_cnt >= accept_wait) begin
            active <= 1'b1;
            spi_cs <= 1'b0;
            sh     <= spi_din;
            nb     <= 0;
          end
        end else if (nb < DW) begin
          mosi <= sh[nb];
          if (nb > 0) rxw[nb-1] <= mosi;
          nb <= nb + 1;
        end else begin
          last_sent <= {mosi, rxw[DW-2:0]};
          sent_cnt  <= sent_cnt + 1;
          spi_cs    <= 1'b1;
          active    <= 1'b0;
          wait_cnt  <= 0;
        end
      end
    end
  end

  int ack_seen = 0;
  always @(negedge clk) if (|ack) ack_seen <= ack_seen + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transfer; called in an IDLE cycle at a negedge, returns in the
  // IDLE cycle after the ack.
  task automatic do_xfer(input logic [NREQ-1:0] r, input int exp_idx, input logic exp_err,
                         input int budget, input logic keep, output int cyc);
    int              start_sent, viol, g;
    logic            accepted;
    logic [NREQ-1:0] onehot;
    onehot = '0;
    onehot[exp_idx] = 1'b1;
    start_sent = sent_cnt;
    req = r;
    g = 0;
    while (gnt == '0 && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("gnt", 32'(gnt), 32'(onehot));
    check("spi_din", 32'(spi_din), 32'(words[exp_idx]));
    check("busy", 32'(busy), 32'd1);
    cyc = 0;
    viol = 0;
    accepted = 1'b0;
    while (ack == '0 && cyc < budget) begin
      if (!spi_cs) accepted = 1'b1;
      if (!accepted && !spi_newd) viol++;
      @(negedge clk);
      cyc++;
    end
    check("ack", 32'(ack), 32'(onehot));
    check("err", 32'(err), 32'(exp_err));
    check("gnt_at_ack", 32'(gnt), 32'd0);
    check("newd_hold", 32'(viol), 32'd0);
    if (exp_err) begin
      check("sent_none", 32'(sent_cnt - start_sent), 32'd0);
    end else begin
      check("sent_once", 32'(sent_cnt - start_sent), 32'd1);
      check("mosi_word", 32'(last_sent), 32'(words[exp_idx]));
    end
    if (!keep) req = '0;
    @(negedge clk);
    check("ack_pulse", 32'(ack), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [NREQ-1:0] r;
    int              idx;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int cyc, g, acks_before;

    // Grants expected from the rotating priority (last starts at 3).
    vecs[0]  = '{4'b1111, 0};
    vecs[1]  = '{4'b1110, 1};
    vecs[2]  = '{4'b1100, 2};
    vecs[3]  = '{4'b1000, 3};
    vecs[4]  = '{4'b0010, 1};
    vecs[5]  = '{4'b1111, 2};
    vecs[6]  = '{4'b0011, 0};
    vecs[7]  = '{4'b1001, 3};
    vecs[8]  = '{4'b0101, 0};
    vecs[9]  = '{4'b0101, 2};
    vecs[10] = '{4'b0001, 0};

    words[0] = 12'h123;
    words[1] = 12'hA5C;
    words[2] = 12'h3C7;
    words[3] = 12'hF0E;
    wdata = {words[3], words[2], words[1], words[0]};
    req = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_newd", 32'(spi_newd), 32'd0);
    check("rst_din", 32'(spi_din), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      do_xfer(vecs[i].r, vecs[i].idx, 1'b0, 300, 1'b0, cyc);

    // Fairness: requesters 0 and 2 held high throughout (last is 0 here).
    do_xfer(4'b0101, 2, 1'b0, 300, 1'b1, cyc);
    do_xfer(4'b0101, 0, 1'b0, 300, 1'b1, cyc);
    do_xfer(4'b0101, 2, 1'b0, 300, 1'b1, cyc);
    do_xfer(4'b0101, 0, 1'b0, 300, 1'b0, cyc);

    // Slow acceptance: newd must be held until cs falls; one word sent.
    accept_wait = 20;
    do_xfer(4'b0010, 1, 1'b0, 300, 1'b0, cyc);
    accept_wait = 0;

    // Timeout with cs stuck high.
    stuck = 1'b1;
    do_xfer(4'b1000, 3, 1'b1, 1100, 1'b0, cyc);
    check("timeout_cycles", 32'(cyc), 32'(TIMEOUT));
    check("newd_after_timeout", 32'(spi_newd), 32'd0);
    stuck = 1'b0;
    do_xfer(4'b1000, 3, 1'b0, 300, 1'b0, cyc);

    // Reset in the middle of a transfer.
    req = 4'b0010;
    g = 0;
    while (!(busy && !spi_newd && !spi_cs) && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("reached_busy", 32'(busy && !spi_newd && !spi_cs), 32'd1);
    acks_before = ack_seen;
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_newd", 32'(spi_newd), 32'd0);
    check("mid_rst_din", 32'(spi_din), 32'd0);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("no_ack_after_rst", 32'(ack_seen - acks_before), 32'd0);
    do_xfer(4'b0100, 2, 1'b0, 300, 1'b0, cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter that shares one 12-bit SPI master transmitter between `NREQ` on-chip requesters. It latches the granted requester's word and drives the master's `newd`/`din` inputs. It watches the master's `cs` to detect acceptance and completion, then returns a one-cycle acknowledge with an error flag. It sits between the requesting blocks and the SPI master and runs entirely on `clk`.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `DW`, 12: data word width; must match the SPI master's `din`.
- `TIMEOUT`, 1024: max `clk` cycles from launch to completion before abort.

Ports:
- `clk`, in, 1: system clock; same clock that feeds the SPI master.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, `NREQ`: per-requester level request.
- `wdata`, in, `NREQ*DW`: packed words; requester i occupies bits `[i*DW +: DW]`. Must be held stable while `req[i]` is high.
- `gnt`, out, `NREQ`: one-hot grant; high from latch until ack.
- `ack`, out, `NREQ`: one-hot, one-cycle completion pulse.
- `err`, out, 1: valid with `ack`; 1 means timeout abort.
- `busy`, out, 1: high in any state except IDLE.
- `spi_newd`, out, 1: drives the master's `newd`.
- `spi_din`, out, `DW`: drives the master's `din`; holds the latched word.
- `spi_cs`, in, 1: the master's `cs`, active-low. Treated as asynchronous and passed through a 2-flop synchronizer (`cs_s`).

## Operation
- FSM states: IDLE, LAUNCH, BUSY, DONE.
- **IDLE**
  - If any `req` bit is high, select the first set bit searching upward from `last+1`, with wrap-around.
  - Latch `wdata` for that requester into `spi_din`.
  - Set `gnt`, `spi_newd` = 1, clear the timeout counter, and go to LAUNCH.
  - If no request is pending, stay in IDLE.
- **LAUNCH**
  - Hold `spi_newd` = 1. The master samples it only on its slow `sclk`, so it must be held until acceptance.
  - On `cs_s` == 0: drop `spi_newd` and go to BUSY.
- **BUSY**
  - On `cs_s` == 1: go to DONE with `err` = 0.
- **DONE**
  - For exactly one cycle: `ack[g]` = 1, `err` valid, `gnt` = 0, and `last` is updated to g.
  - Then go to IDLE.
- **Timeout**
  - The counter increments every cycle in LAUNCH and BUSY.
  - When it reaches `TIMEOUT-1`: go to DONE with `err` = 1 and force `spi_newd` = 0.
  - Counter width is `$clog2(TIMEOUT)`; it saturates and never wraps.
- Requester rule: on the edge where it samples `ack[i]` = 1, the requester either deasserts `req[i]` or presents a new word.
  - If `req[i]` is still high in the following IDLE cycle, that is a new request.
  - Round-robin places that requester last, so no requester can starve another.
- Changes to `req` while `busy` = 1 are ignored; there is no preemption.
- A requester dropping `req` after grant does not cancel the transfer; its ack is still issued.

## Timing
- Reset values: `gnt` = 0, `ack` = 0, `err` = 0, `busy` = 0, `spi_newd` = 0, `spi_din` = 0, `last` = `NREQ-1` (requester 0 has first priority), state = IDLE, synchronizer flops = 1.
- `rst` asserted mid-transfer returns the block to IDLE next edge with no ack issued. The SPI master shares the same `rst`.
- Latency, `req` high in IDLE to `spi_newd` high: 1 cycle (registered).
- Completion: `ack` goes high 1 cycle after BUSY sees `cs_s` = 1. The synchronizer adds a 2-cycle lag behind raw `spi_cs`.
- All outputs are registered.
- Simultaneous requests are resolved in the same IDLE cycle; only one grant is ever active.
- `ack` and a new grant are never issued in the same cycle. The minimum gap between transfers is 2 cycles (DONE, then IDLE).

## Structure
- Package `spi_ctrl_pkg`: state enum `arb_state_t` (IDLE, LAUNCH, BUSY, DONE) and the default constants `SPI_DW` = 12 and `SPI_TIMEOUT` = 1024.
- Sub-module `rr_arbiter`, parameterized by `NREQ`:
  - Inputs: `req`, `last`.
  - Outputs: one-hot `sel` and its index.
  - Purely combinational.
- The top level contains the FSM, data latch, timeout counter and `cs` synchronizer.

## Test plan
- **Single transfer:** `req[1]`=1, word 0xA5C; model the SPI master. Expect `spi_din`=0xA5C, `spi_newd` held until `cs` falls, `ack[1]` pulses once with `err`=0, `gnt[1]` cleared.
- **Simultaneous requests:** `req`=4'b1111 right after reset. Expect grant order 0,1,2,3, each word appearing serially on the master's mosi, LSB first.
- **Fairness:** `req[0]` and `req[2]` held permanently high. Expect grants alternating 0,2,0,2 with no back-to-back repeat.
- **Timeout:** `spi_cs` stuck at 1 and `req[3]`=1. Expect `ack[3]`=1 with `err`=1 after 1024 cycles and `spi_newd`=0 afterwards. Then the next request is served normally.
- **Reset mid-transfer:** `rst` pulsed in BUSY. Expect all outputs at reset values next cycle, no ack, and the following `req[2]` served.
- **Hold check:** the master's `sclk` phase delays acceptance by 20 cycles. Expect `spi_newd` to stay high the whole time and the word to be sent exactly once.
